// File: rtl/iob_timer_sched_pkg.sv
// Shared types and default register map for the timer scheduler.
package iob_timer_sched_pkg;

   // Top-level sequencer states
   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SET,
      ST_CLR,
      ST_RDLO,
      ST_RDHI,
      ST_DONE,
      ST_FAIL
   } state_t;

   // Sub-phase of a bus state: launch pending, waiting for ready, gap cycle
   typedef enum logic [1:0] {
      PH_LAUNCH,
      PH_ACTIVE,
      PH_GAP
   } phase_t;

   // Default iob_timer register word addresses
   localparam int unsigned DEF_ADDR_ENABLE    = 1;
   localparam int unsigned DEF_ADDR_SAMPLE    = 2;
   localparam int unsigned DEF_ADDR_DATA_LOW  = 3;
   localparam int unsigned DEF_ADDR_DATA_HIGH = 4;

endpackage

// File: rtl/iob_timer_sched_arb.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module iob_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] grant_c,
   output logic [IDX_W-1:0] grant_idx_c,
   output logic             any_c
);

   // Scan from the pointer and keep only the first hit
   always_comb begin : arb
      int unsigned idx;
      idx         = 0;
      grant_c     = '0;
      grant_idx_c = '0;
      any_c       = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = (32'(ptr) + k) % N_REQ;
         if (!any_c && req[IDX_W'(idx)]) begin
            any_c                   = 1'b1;
            grant_idx_c             = IDX_W'(idx);
            grant_c[IDX_W'(idx)]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/iob_timer_sched.sv
// Shares one iob_timer between requesters: SAMPLE=1, SAMPLE=0, read LOW, read HIGH.
module iob_timer_sched
   import iob_timer_sched_pkg::*;
#(
   parameter int unsigned N_REQ          = 4,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 3,
   parameter int unsigned WDATA_W        = 1,
   parameter int unsigned AUTO_ENABLE    = 1,
   parameter int unsigned TIMEOUT        = 15,
   parameter int unsigned ADDR_ENABLE    = DEF_ADDR_ENABLE,
   parameter int unsigned ADDR_SAMPLE    = DEF_ADDR_SAMPLE,
   parameter int unsigned ADDR_DATA_LOW  = DEF_ADDR_DATA_LOW,
   parameter int unsigned ADDR_DATA_HIGH = DEF_ADDR_DATA_HIGH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   output logic [N_REQ-1:0]      ack,
   output logic [N_REQ-1:0]      err,
   output logic [2*DATA_W-1:0]   tstamp,
   output logic                  init_done,
   output logic                  m_valid,
   output logic [ADDR_W-1:0]     m_address,
   output logic [WDATA_W-1:0]    m_wdata,
   output logic [DATA_W/8-1:0]   m_wstrb,
   input  logic [DATA_W-1:0]     m_rdata,
   input  logic                  m_ready
);

   localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   state_t               state_q, state_d;
   phase_t               ph_q, ph_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [N_REQ-1:0]     ack_d, err_d;
   logic [2*DATA_W-1:0]  tstamp_d;
   logic                 init_done_d;
   logic                 m_valid_d;
   logic [ADDR_W-1:0]    m_address_d;
   logic [WDATA_W-1:0]   m_wdata_d;
   logic [STRB_W-1:0]    m_wstrb_d;

   logic                 launch;
   logic [ADDR_W-1:0]    l_addr;
   logic                 l_wr;
   logic                 l_wbit;

   logic [N_REQ-1:0]     grant_c;
   logic [IDX_W-1:0]     grant_idx_c;
   logic                 any_c;

   iob_rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req         (req),
      .ptr         (ptr_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c),
      .any_c       (any_c)
   );

   // State, pointer, counters and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= (AUTO_ENABLE != 0) ? ST_INIT : ST_IDLE;
         ph_q      <= PH_LAUNCH;
         cnt_q     <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         ack       <= '0;
         err       <= '0;
         tstamp    <= '0;
         init_done <= (AUTO_ENABLE != 0) ? 1'b0 : 1'b1;
         m_valid   <= 1'b0;
         m_address <= '0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         ack       <= ack_d;
         err       <= err_d;
         tstamp    <= tstamp_d;
         init_done <= init_done_d;
         m_valid   <= m_valid_d;
         m_address <= m_address_d;
         m_wdata   <= m_wdata_d;
         m_wstrb   <= m_wstrb_d;
      end
   end

   // Next-state, bus phase sequencing, capture and ack/err generation
   always_comb begin
      state_d     = state_q;
      ph_d        = ph_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      err_d       = '0;
      tstamp_d    = tstamp;
      init_done_d = init_done;
      m_valid_d   = m_valid;
      m_address_d = m_address;
      m_wdata_d   = m_wdata;
      m_wstrb_d   = m_wstrb;
      launch      = 1'b0;
      l_addr      = '0;
      l_wr        = 1'b0;
      l_wbit      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (any_c) begin
               gnt_d   = grant_c;
               ptr_d   = (grant_idx_c == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
               state_d = ST_SET;
               launch  = 1'b1;
               l_addr  = ADDR_W'(ADDR_SAMPLE);
               l_wr    = 1'b1;
               l_wbit  = 1'b1;
            end
         end
         ST_DONE: begin
            ack_d   = gnt_q & req;
            state_d = ST_IDLE;
         end
         ST_FAIL: begin
            err_d   = gnt_q;
            state_d = ST_IDLE;
         end
         default: begin
            case (ph_q)
               PH_LAUNCH: begin
                  // Only reachable in INIT: after reset or a timed-out enable write
                  launch = 1'b1;
                  l_addr = ADDR_W'(ADDR_ENABLE);
                  l_wr   = 1'b1;
                  l_wbit = 1'b1;
               end
               PH_ACTIVE: begin
                  if (m_valid && m_ready) begin
                     m_valid_d = 1'b0;
                     ph_d      = PH_GAP;
                     if (state_q == ST_RDLO) tstamp_d[DATA_W-1:0] = m_rdata;
                     if (state_q == ST_RDHI) tstamp_d[2*DATA_W-1:DATA_W] = m_rdata;
                  end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                     m_valid_d = 1'b0;
                     if (state_q == ST_INIT) ph_d = PH_LAUNCH;
                     else                    state_d = ST_FAIL;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               PH_GAP: begin
                  case (state_q)
                     ST_INIT: begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                     end
                     ST_SET: begin
                        state_d = ST_CLR;
                        launch  = 1'b1;
                        l_addr  = ADDR_W'(ADDR_SAMPLE);
                        l_wr    = 1'b1;
                     end
                     ST_CLR: begin
                        state_d = ST_RDLO;
                        launch  = 1'b1;
                        l_addr  = ADDR_W'(ADDR_DATA_LOW);
                     end
                     ST_RDLO: begin
                        state_d = ST_RDHI;
                        launch  = 1'b1;
                        l_addr  = ADDR_W'(ADDR_DATA_HIGH);
                     end
                     ST_RDHI: state_d = ST_DONE;
                     default: state_d = ST_IDLE;
                  endcase
               end
               default: ph_d = PH_GAP;
            endcase
         end
      endcase

      // Common bus launch: valid plus payload go out together on phase entry
      if (launch) begin
         m_valid_d   = 1'b1;
         m_address_d = l_addr;
         m_wdata_d   = WDATA_W'(l_wbit);
         m_wstrb_d   = l_wr ? {STRB_W{1'b1}} : '0;
         ph_d        = PH_ACTIVE;
         cnt_d       = '0;
      end
   end

endmodule
